// File: rtl/fetch_pkg.sv
// Shared fetch/decode constants, FSM states and the IF/ID bundle.
// The decoder imports NOP_INSTR and INTR_INSTR from here too.
package fetch_pkg;

  localparam logic [15:0] NOP_INSTR  = 16'h0000;
  localparam logic [15:0] INTR_INSTR = 16'hC0C0;

  typedef enum logic {
    FETCH,
    IMM_WAIT
  } state_t;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] imm;
    logic        valid;
  } ifid_t;

  function automatic logic is_two_word(
    input logic [15:0] word
  );
    return (word[15:14] == 2'b00) && word[11];
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: instruction memory, control inputs
// and the IF/ID outputs towards the decoder.
interface fetch_if #(
  parameter int PC_WIDTH = 10
);

  logic [PC_WIDTH-1:0] imem_addr;
  logic [15:0]         imem_rdata;
  logic                stall;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic                intr_req;
  logic                intr_ret;
  logic [15:0]         ifid_instr;
  logic [15:0]         ifid_imm;
  logic [PC_WIDTH-1:0] ifid_pc;
  logic                ifid_valid;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  redirect_valid,
    input  redirect_pc,
    input  intr_req,
    input  intr_ret,
    output ifid_instr,
    output ifid_imm,
    output ifid_pc,
    output ifid_valid
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output redirect_valid,
    output redirect_pc,
    output intr_req,
    output intr_ret,
    input  ifid_instr,
    input  ifid_imm,
    input  ifid_pc,
    input  ifid_valid
  );

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with hold (stall) and bubble insert.
// A bubble wins over hold so a redirect under stall still flushes.
module ifid_reg
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                hold,
  input  logic                bubble,
  input  ifid_t               d,
  input  logic [PC_WIDTH-1:0] d_pc,
  output ifid_t               q,
  output logic [PC_WIDTH-1:0] q_pc
);

  localparam ifid_t BUBBLE = '{
    instr: NOP_INSTR,
    imm:   16'h0000,
    valid: 1'b0
  };

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q    <= BUBBLE;
      q_pc <= '0;
    end else if (bubble) begin
      q    <= BUBBLE;
      q_pc <= '0;
    end else if (!hold) begin
      q    <= d;
      q_pc <= d_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, two-word assembly FSM, redirect,
// stall and interrupt injection feeding the IF/ID register.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH     = 10,
  parameter int RESET_VECTOR = 0,
  parameter int INTR_VECTOR  = 1
) (
  input logic     clk,
  input logic     rst_n,
  fetch_if.master bus
);

  typedef logic [PC_WIDTH-1:0] pc_t;

  state_t      state, state_n;
  pc_t         pc, pc_n, pc_inc, d_pc, q_pc;
  logic [15:0] held_op, held_n;
  logic        pending, pending_n;
  logic        in_isr, in_isr_n;
  logic        inject, hold, bubble;
  logic        do_redir, do_hold, do_imm, do_two;
  ifid_t       d, q;

  assign pc_inc        = pc + pc_t'(1);
  assign bus.imem_addr = pc;

  assign inject = (state == FETCH) && pending && !in_isr
               && !bus.stall && !bus.redirect_valid;

  // One-hot selects so the decoder below is truly unique
  assign do_redir = bus.redirect_valid;
  assign do_hold  = bus.stall && !bus.redirect_valid;
  assign do_imm   = (state == IMM_WAIT) && !bus.stall
                 && !bus.redirect_valid;
  assign do_two   = (state == FETCH) && !bus.stall
                 && !bus.redirect_valid && !inject
                 && is_two_word(bus.imem_rdata);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= pc_t'(RESET_VECTOR);
      held_op <= NOP_INSTR;
      pending <= 1'b0;
      in_isr  <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      held_op <= held_n;
      pending <= pending_n;
      in_isr  <= in_isr_n;
    end
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    held_n    = held_op;
    hold      = 1'b0;
    bubble    = 1'b0;
    d         = '{instr: bus.imem_rdata,
                  imm:   16'h0000,
                  valid: 1'b1};
    d_pc      = pc_inc;
    pending_n = bus.intr_req || (pending && !inject);
    in_isr_n  = inject || (in_isr && !bus.intr_ret);
    unique case (1'b1)
      do_redir: begin
        pc_n    = bus.redirect_pc;
        state_n = FETCH;
        held_n  = NOP_INSTR;
        bubble  = 1'b1;
      end
      do_hold: hold = 1'b1;
      inject: begin
        d.instr = INTR_INSTR;
        d_pc    = pc;
        pc_n    = pc_t'(INTR_VECTOR);
      end
      do_imm: begin
        d.instr = held_op;
        d.imm   = bus.imem_rdata;
        pc_n    = pc_inc;
        state_n = FETCH;
      end
      do_two: begin
        held_n  = bus.imem_rdata;
        bubble  = 1'b1;
        pc_n    = pc_inc;
        state_n = IMM_WAIT;
      end
      default: pc_n = pc_inc;
    endcase
  end

  ifid_reg #(
    .PC_WIDTH(PC_WIDTH)
  ) u_ifid (
    .clk   (clk),
    .rst_n (rst_n),
    .hold  (hold),
    .bubble(bubble),
    .d     (d),
    .d_pc  (d_pc),
    .q     (q),
    .q_pc  (q_pc)
  );

  assign bus.ifid_instr = q.instr;
  assign bus.ifid_imm   = q.imm;
  assign bus.ifid_valid = q.valid;
  assign bus.ifid_pc    = q_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed plus random bench for fetch_unit against an
// instruction-level reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int PW = 10;
  localparam int MS = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.PC_WIDTH(PW)) bus ();

  fetch_unit #(
    .PC_WIDTH    (PW),
    .RESET_VECTOR(0),
    .INTR_VECTOR (1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [15:0] mem [MS];
  assign bus.imem_rdata = mem[bus.imem_addr];

  int n_pass = 0;
  int n_total = 0;

  int          m_pc;
  bit          m_wait, m_pend, m_isr;
  logic [15:0] m_op;
  logic [15:0] e_instr, e_imm;
  int          e_pc;
  bit          e_valid;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
  endtask

  task automatic drive(bit r, bit st, bit rv, int rpc,
                       bit irq, bit iret);
    rst_n              = r;
    bus.stall          = st;
    bus.redirect_valid = rv;
    bus.redirect_pc    = PW'(rpc);
    bus.intr_req       = irq;
    bus.intr_ret       = iret;
  endtask

  task automatic issue(logic [15:0] i, logic [15:0] m, int p);
    e_instr = i; e_imm = m; e_pc = p; e_valid = 1;
  endtask

  task automatic flush();
    e_instr = NOP_INSTR; e_imm = 0; e_valid = 0;
  endtask

  // Effect of one clock edge, from the instruction-level rules
  task automatic model_step();
    logic [15:0] w;
    bit fire, np, ni;
    int nxt;
    if (!rst_n) begin
      m_pc = 0; m_wait = 0; m_pend = 0; m_isr = 0;
      flush(); e_pc = 0;
      return;
    end
    w    = mem[m_pc];
    nxt  = (m_pc + 1) % MS;
    fire = !m_wait && m_pend && !m_isr
        && !bus.stall && !bus.redirect_valid;
    np   = bus.intr_req || (m_pend && !fire);
    ni   = fire || (m_isr && !bus.intr_ret);
    if (bus.redirect_valid) begin
      m_pc = int'(bus.redirect_pc); m_wait = 0; flush();
    end else if (bus.stall) begin
    end else if (fire) begin
      issue(INTR_INSTR, 0, m_pc); m_pc = 1;
    end else if (m_wait) begin
      issue(m_op, w, nxt); m_pc = nxt; m_wait = 0;
    end else if (w[15:14] == 2'b00 && w[11]) begin
      m_op = w; m_wait = 1; flush(); m_pc = nxt;
    end else begin
      issue(w, 0, nxt); m_pc = nxt;
    end
    m_pend = np;
    m_isr  = ni;
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    check("addr", 32'(bus.imem_addr), 32'(m_pc));
    check("valid", 32'(bus.ifid_valid), 32'(e_valid));
    check("instr", 32'(bus.ifid_instr), 32'(e_instr));
    check("imm", 32'(bus.ifid_imm), 32'(e_imm));
    if (e_valid) check("pc", 32'(bus.ifid_pc), 32'(e_pc));
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0);
    step();
  endtask

  initial begin
    for (int i = 0; i < MS; i++) mem[i] = 16'($urandom);
    mem[0]    = 16'h1000; mem[1]  = 16'h1001;
    mem[2]    = 16'h1002; mem[3]  = 16'h1003;
    mem[4]    = 16'h0800; mem[5]  = 16'hBEEF;
    mem[8]    = 16'h0800;
    mem[19]   = 16'h3019; mem[20] = 16'h3000;
    mem[30]   = 16'h0800; mem[31] = 16'hABCD;
    mem[32]   = 16'h1111;
    mem[256]  = 16'h1234; mem[1023] = 16'h2222;

    drive(0, 0, 0, 0, 0, 0);
    step(); step();
    check("rst_valid", 32'(bus.ifid_valid), 0);
    check("rst_addr", 32'(bus.imem_addr), 0);
    idle();
    check("line0", {bus.ifid_instr, 6'd0, bus.ifid_pc},
          {16'h1000, 16'd1});
    idle();
    check("line1", {bus.ifid_instr, 6'd0, bus.ifid_pc},
          {16'h1001, 16'd2});

    drive(1, 0, 1, 4, 0, 0); step();
    idle();
    check("tw_bubble", 32'(bus.ifid_valid), 0);
    idle();
    check("tw_op", 32'(bus.ifid_instr), 32'h0800);
    check("tw_imm", 32'(bus.ifid_imm), 32'hBEEF);
    check("tw_pc", 32'(bus.ifid_pc), 6);

    drive(1, 0, 1, 8, 0, 0); step();
    idle();
    drive(1, 0, 1, 256, 0, 0); step();
    check("rd_wait", 32'(bus.ifid_valid), 0);
    idle();
    check("rd_tgt", 32'(bus.ifid_instr), 32'h1234);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0, 0, 0); step();
    end
    check("stall_i", 32'(bus.ifid_instr), 32'h1234);
    check("stall_a", 32'(bus.imem_addr), 257);
    drive(1, 1, 1, 1023, 0, 0); step();
    check("st_redir", 32'(bus.imem_addr), 1023);
    idle();
    check("wrap_i", 32'(bus.ifid_instr), 32'h2222);
    check("wrap_pc", 32'(bus.ifid_pc), 0);

    drive(1, 0, 1, 19, 0, 0); step();
    drive(1, 0, 0, 0, 1, 0); step();
    idle();
    check("irq_i", 32'(bus.ifid_instr), 32'hC0C0);
    check("irq_pc", 32'(bus.ifid_pc), 20);
    check("irq_vec", 32'(bus.imem_addr), 1);
    drive(1, 0, 0, 0, 1, 0); step();
    idle();
    check("irq_mask", 32'(bus.ifid_instr), 32'h1002);
    drive(1, 0, 0, 0, 0, 1); step();
    idle();
    check("irq_re", 32'(bus.ifid_instr), 32'hC0C0);
    check("irq_re_pc", 32'(bus.ifid_pc), 4);

    drive(1, 0, 1, 30, 0, 1); step();
    drive(1, 0, 0, 0, 1, 0); step();
    idle();
    check("itw_op", 32'(bus.ifid_instr), 32'h0800);
    check("itw_imm", 32'(bus.ifid_imm), 32'hABCD);
    idle();
    check("itw_irq", 32'(bus.ifid_instr), 32'hC0C0);
    check("itw_pc", 32'(bus.ifid_pc), 32);

    for (int i = 0; i < 3000; i++) begin
      int rpc;
      rpc = ($urandom_range(0, 9) == 0) ? 1023
                                        : int'($urandom_range(0, 1023));
      drive($urandom_range(0, 99) != 0,
            $urandom_range(0, 4) == 0,
            $urandom_range(0, 11) == 0, rpc,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 15) == 0);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
